// File: rtl/video_stream_tx.sv
// video_stream_tx
//   Raster test-pattern source. It streams H_ACT x V_ACT frames of RGB565
//   pixels. The handshake is pix_valid/ready. Each line is followed by H_GAP
//   idle cycles, and the last line of a frame gets V_GAP further idle cycles.
//   The pattern and the enable request are sampled only at frame boundaries.
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   enable           request to stream frames
//   pattern[1:0]     0 colour bars, 1 gray ramp, 2 checkerboard, 3 ROI mask
//   ready            downstream accepts pix_data this cycle
//   pix_data[15:0]   RGB565 pixel, qualified by pix_valid
//   pix_valid        pixel present; transfer on pix_valid && ready
//   frame_start      marks pixel (0,0)
//   line_end         marks pixel x = H_ACT-1
//   roi              pixel lies inside the inclusive ROI rectangle
//   cnt_x, cnt_y     coordinates of the presented pixel
//   frame_cnt        completed frames, wraps at 256
module video_stream_tx #(
  parameter int H_ACT  = 800,
  parameter int V_ACT  = 600,
  parameter int H_GAP  = 16,
  parameter int V_GAP  = 4,
  parameter int ROI_X0 = 150,
  parameter int ROI_X1 = 450,
  parameter int ROI_Y0 = 50,
  parameter int ROI_Y1 = 350
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic        ready,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        line_end,
  output logic        roi,
  output logic [11:0] cnt_x,
  output logic [11:0] cnt_y,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

  localparam logic [11:0] X_LAST  = 12'(H_ACT - 1);
  localparam logic [11:0] Y_LAST  = 12'(V_ACT - 1);
  localparam logic [11:0] BAR_W   = 12'(H_ACT / 8);
  localparam logic [11:0] RX0     = 12'(ROI_X0);
  localparam logic [11:0] RX1     = 12'(ROI_X1);
  localparam logic [11:0] RY0     = 12'(ROI_Y0);
  localparam logic [11:0] RY1     = 12'(ROI_Y1);
  localparam logic [15:0] HG_LAST = 16'(H_GAP - 1);
  localparam logic [15:0] VG_LAST = 16'(V_GAP - 1);

  state_t      r_state, w_state_p0;
  logic [11:0] r_x_p1, r_y_p1, w_x_p0, w_y_p0;
  logic [1:0]  r_pat, w_pat_p0;
  logic [15:0] r_gap, w_gap_p0;
  logic [7:0]  r_frame_cnt_p1, w_frame_cnt_p0;
  logic        w_vld_p0, w_fs_p0, w_le_p0, w_roi_p0;
  logic [15:0] w_pix_p0;
  logic        r_vld_p1, r_fs_p1, r_le_p1, r_roi_p1;
  logic [15:0] r_pix_p1;

  function automatic logic f_in_roi(input logic [11:0] x, input logic [11:0] y);
    return (x >= RX0) && (x <= RX1) && (y >= RY0) && (y <= RY1);
  endfunction

  function automatic logic [15:0] f_pixel(input logic [1:0] pat, input logic [11:0] x,
                                          input logic [11:0] y, input logic in_roi);
    logic [2:0]  bar;
    logic [7:0]  g;
    logic [15:0] pix;
    bar = 3'd0;
    // Bar index by threshold compare, so no divider is needed for any H_ACT.
    for (int i = 1; i < 8; i++) begin
      if (x >= 12'(i) * BAR_W) bar = 3'(i);
    end
    g   = x[9:2];
    pix = 16'h0000;
    case (pat)
      2'd0: begin
        case (bar)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = {g[7:3], g[7:2], g[7:3]};
      2'd2:    pix = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
      default: pix = in_roi ? 16'hFFFF : 16'h0000;
    endcase
    return pix;
  endfunction

  // Stage p0: next state, next coordinate and next output values.
  // Outputs are formed from the next coordinates so that every output port is a flop.
  always_comb begin
    w_state_p0     = r_state;
    w_x_p0         = r_x_p1;
    w_y_p0         = r_y_p1;
    w_pat_p0       = r_pat;
    w_gap_p0       = r_gap;
    w_frame_cnt_p0 = r_frame_cnt_p1;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_p0 = ACTIVE;
          w_pat_p0   = pattern;
          w_x_p0     = '0;
          w_y_p0     = '0;
        end
      end
      ACTIVE: begin
        // pix_valid is always 1 in ACTIVE, so ready alone completes a transfer.
        if (ready) begin
          if (r_x_p1 == X_LAST) begin
            w_state_p0 = HBLANK;
            w_gap_p0   = '0;
          end else begin
            w_x_p0 = r_x_p1 + 12'd1;
          end
        end
      end
      HBLANK: begin
        if (r_gap == HG_LAST) begin
          w_gap_p0 = '0;
          if (r_y_p1 == Y_LAST) begin
            w_state_p0     = VBLANK;
            w_frame_cnt_p0 = r_frame_cnt_p1 + 8'd1;
          end else begin
            w_state_p0 = ACTIVE;
            w_x_p0     = '0;
            w_y_p0     = r_y_p1 + 12'd1;
          end
        end else begin
          w_gap_p0 = r_gap + 16'd1;
        end
      end
      VBLANK: begin
        if (r_gap == VG_LAST) begin
          w_gap_p0 = '0;
          w_x_p0   = '0;
          w_y_p0   = '0;
          if (enable) begin
            w_state_p0 = ACTIVE;
            w_pat_p0   = pattern;
          end else begin
            w_state_p0 = IDLE;
          end
        end else begin
          w_gap_p0 = r_gap + 16'd1;
        end
      end
      default: w_state_p0 = IDLE;
    endcase
    w_vld_p0 = (w_state_p0 == ACTIVE);
    w_roi_p0 = w_vld_p0 && f_in_roi(w_x_p0, w_y_p0);
    w_fs_p0  = w_vld_p0 && (w_x_p0 == 12'd0) && (w_y_p0 == 12'd0);
    w_le_p0  = w_vld_p0 && (w_x_p0 == X_LAST);
    w_pix_p0 = w_vld_p0 ? f_pixel(w_pat_p0, w_x_p0, w_y_p0, w_roi_p0) : 16'h0000;
  end

  // Stage p1: state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_x_p1         <= '0;
      r_y_p1         <= '0;
      r_pat          <= '0;
      r_gap          <= '0;
      r_frame_cnt_p1 <= '0;
      r_vld_p1       <= 1'b0;
      r_fs_p1        <= 1'b0;
      r_le_p1        <= 1'b0;
      r_roi_p1       <= 1'b0;
      r_pix_p1       <= '0;
    end else begin
      r_state        <= w_state_p0;
      r_x_p1         <= w_x_p0;
      r_y_p1         <= w_y_p0;
      r_pat          <= w_pat_p0;
      r_gap          <= w_gap_p0;
      r_frame_cnt_p1 <= w_frame_cnt_p0;
      r_vld_p1       <= w_vld_p0;
      r_fs_p1        <= w_fs_p0;
      r_le_p1        <= w_le_p0;
      r_roi_p1       <= w_roi_p0;
      r_pix_p1       <= w_pix_p0;
    end
  end

  assign pix_data    = r_pix_p1;
  assign pix_valid   = r_vld_p1;
  assign frame_start = r_fs_p1;
  assign line_end    = r_le_p1;
  assign roi         = r_roi_p1;
  assign cnt_x       = r_x_p1;
  assign cnt_y       = r_y_p1;
  assign frame_cnt   = r_frame_cnt_p1;

endmodule

// File: tb/tb_video_stream_tx.sv
// tb_video_stream_tx
//   Self-checking bench for video_stream_tx. It uses a reduced 64x48 raster
//   so that several whole frames run in a short simulation. Expected pixels
//   come from a raster-order model: the k-th transferred pixel sits at
//   (k % H_ACT, k / H_ACT). Pixel values come from the pattern formulas.
module tb_video_stream_tx;

  localparam int H_ACT  = 64;
  localparam int V_ACT  = 48;
  localparam int H_GAP  = 16;
  localparam int V_GAP  = 4;
  localparam int RX0    = 10;
  localparam int RX1    = 40;
  localparam int RY0    = 5;
  localparam int RY1    = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic        ready = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid, frame_start, line_end, roi;
  logic [11:0] cnt_x, cnt_y;
  logic [7:0]  frame_cnt;

  int          checks = 0;
  int          passes = 0;
  logic [7:0]  exp_frames = 8'd0;

  video_stream_tx #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .H_GAP(H_GAP), .V_GAP(V_GAP),
    .ROI_X0(RX0), .ROI_X1(RX1), .ROI_Y0(RY0), .ROI_Y1(RY1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern(pattern), .ready(ready),
    .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start),
    .line_end(line_end), .roi(roi), .cnt_x(cnt_x), .cnt_y(cnt_y),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit in_roi_m(int x, int y);
    return (x >= RX0) && (x <= RX1) && (y >= RY0) && (y <= RY1);
  endfunction

  function automatic logic [15:0] model_pix(int pat, int x, int y);
    int g, r5, g6;
    case (pat)
      0: begin
        case (x / (H_ACT / 8))
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: begin
        g  = (x / 4) % 256;
        r5 = g / 8;
        g6 = g / 4;
        return 16'(r5 * 2048 + g6 * 32 + r5);
      end
      2: return ((((x / 32) + (y / 32)) % 2) == 1) ? 16'hFFFF : 16'h0000;
      default: return in_roi_m(x, y) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  function automatic logic [51:0] all_outs();
    return {pix_valid, pix_data, frame_start, line_end, roi, cnt_x, cnt_y, frame_cnt};
  endfunction

  // Streams one whole frame. Entry: the next negedge shows pixel (0,0).
  // Exit: at the negedge of the last blank cycle of the frame.
  // When pixel index chg_at is on screen, pattern/enable are changed to pat_next/en_next.
  task automatic stream_frame(input int pat, input int rdy_pct, input int chg_at,
                              input logic [1:0] pat_next, input logic en_next,
                              input string tag);
    int         k, blank, bi, cyc, ex, ey;
    bit         last_line, done;
    logic [51:0] act_v, exp_v;
    logic [23:0] act_b, exp_b;
    logic [7:0]  exp_fc;
    k = 0; blank = 0; bi = 0; cyc = 0; last_line = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 4 * H_ACT * V_ACT + 100) begin
        checks++;
        $display("FAIL %s_budget: frame not finished, transfers=%0d required=%0d", tag, k, H_ACT * V_ACT);
        return;
      end
      if (blank == 0) begin
        ex = k % H_ACT;
        ey = k / H_ACT;
        exp_v = {1'b1, model_pix(pat, ex, ey), (k == 0), (ex == H_ACT - 1), in_roi_m(ex, ey),
                 12'(ex), 12'(ey), exp_frames};
        act_v = all_outs();
        checks++;
        if (act_v !== exp_v)
          $display("FAIL %s_pixel (%0d,%0d): got {v,data,fs,le,roi,x,y,fc}=%h required %h",
                   tag, ex, ey, act_v, exp_v);
        else
          passes++;
        if (k == chg_at) begin
          pattern = pat_next;
          enable  = en_next;
        end
        ready = ($urandom_range(99) < rdy_pct);
        if (ready) begin
          k++;
          if (ex == H_ACT - 1) begin
            last_line = (ey == V_ACT - 1);
            blank     = last_line ? H_GAP + V_GAP : H_GAP;
            bi        = 0;
          end
        end
      end else begin
        exp_fc = (last_line && bi >= H_GAP) ? exp_frames + 8'd1 : exp_frames;
        act_b  = {pix_valid, pix_data, frame_start, line_end, roi, frame_cnt};
        exp_b  = {1'b0, 16'h0000, 3'b000, exp_fc};
        checks++;
        if (act_b !== exp_b)
          $display("FAIL %s_blank idx=%0d after line %0d: got {v,data,fs,le,roi,fc}=%h required %h",
                   tag, bi, (k - 1) / H_ACT, act_b, exp_b);
        else
          passes++;
        ready = 1'($urandom_range(1));
        bi++;
        blank--;
        if (blank == 0 && last_line) done = 1;
      end
    end
    exp_frames = exp_frames + 8'd1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 52'd0) $display("FAIL reset_state: got %h required 0", all_outs());
    else passes++;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ready = 1'($urandom_range(1));
      pattern = 2'($urandom_range(3));
      checks++;
      if (all_outs() !== 52'd0) $display("FAIL idle_after_reset cycle %0d: got %h required 0", i, all_outs());
      else passes++;
    end
    exp_frames = 8'd0;
  endtask

  task automatic test_bars();
    pattern = 2'd0;
    enable  = 1'b1;
    stream_frame(0, 100, 0, 2'd1, 1'b0, "bars");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({pix_valid, pix_data, frame_start, line_end, roi, frame_cnt} !== {20'd0, exp_frames})
        $display("FAIL bars_idle cycle %0d: got valid=%b data=%h fc=%0d required valid=0 data=0 fc=%0d",
                 i, pix_valid, pix_data, frame_cnt, exp_frames);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    pattern = 2'd1;
    enable  = 1'b1;
    stream_frame(1, 50, 0, 2'd0, 1'b0, "ramp_bp");
  endtask

  task automatic test_roi();
    pattern = 2'd3;
    enable  = 1'b1;
    stream_frame(3, 75, 0, 2'd3, 1'b0, "roi");
  endtask

  task automatic test_pattern_switch();
    pattern = 2'd0;
    enable  = 1'b1;
    stream_frame(0, 60, 1000, 2'd2, 1'b0, "switch_a");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pix_valid !== 1'b0 || pix_data !== 16'h0000)
        $display("FAIL switch_idle cycle %0d: got valid=%b data=%h required valid=0 data=0",
                 i, pix_valid, pix_data);
      else passes++;
    end
    enable = 1'b1;
    stream_frame(2, 60, 0, 2'd2, 1'b0, "switch_b");
  endtask

  task automatic test_back_to_back();
    pattern = 2'd1;
    enable  = 1'b1;
    stream_frame(1, 100, 3, 2'd2, 1'b1, "b2b_a");
    stream_frame(2, 70, 0, 2'd0, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    bit found;
    found   = 0;
    pattern = 2'd0;
    ready   = 1'b1;
    enable  = 1'b1;
    for (int i = 0; i < 10000 && !found; i++) begin
      @(negedge clk);
      if (pix_valid === 1'b1 && cnt_x === 12'd40 && cnt_y === 12'd30) found = 1;
    end
    checks++;
    if (!found) $display("FAIL rstmid_reach: pixel (40,30) not seen, got x=%0d y=%0d required 40,30", cnt_x, cnt_y);
    else passes++;
    checks++;
    if (frame_cnt !== exp_frames) $display("FAIL rstmid_fc_before: got %0d required %0d", frame_cnt, exp_frames);
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (all_outs() !== 52'd0) $display("FAIL rstmid_zero: got %h required 0", all_outs());
    else passes++;
    exp_frames = 8'd0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs() !== {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 8'd0})
      $display("FAIL rstmid_restart: got %h required %h", all_outs(),
               {1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 8'd0});
    else passes++;
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bars();
    test_backpressure();
    test_roi();
    test_pattern_switch();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/video_stream_tx.md
VIDEO_STREAM_TX -- requirements
Module: video_stream_tx

Interface
REQ-001 Parameter H_ACT, default 800: active pixels per line.
REQ-002 Parameter V_ACT, default 600: active lines per frame.
REQ-003 Parameter H_GAP, default 16: idle cycles after each line.
REQ-004 Parameter V_GAP, default 4: extra idle cycles after the last line of a frame.
REQ-005 Parameters ROI_X0/ROI_X1/ROI_Y0/ROI_Y1, defaults 150/450/50/350: inclusive region-of-interest bounds.
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 enable  in  1  request to stream frames.
REQ-009 pattern  in  2  test pattern select.
REQ-010 ready  in  1  downstream can accept a pixel this cycle.
REQ-011 pix_data  out  16  RGB565 pixel.
REQ-012 pix_valid  out  1  pix_data valid; transfer occurs on pix_valid && ready.
REQ-013 frame_start  out  1  high with pixel (0,0).
REQ-014 line_end  out  1  high with pixel x = H_ACT-1.
REQ-015 roi  out  1  high when the current pixel lies inside the ROI bounds.
REQ-016 cnt_x  out  12  x coordinate of the current pix_data.
REQ-017 cnt_y  out  12  y coordinate of the current pix_data.
REQ-018 frame_cnt  out  8  count of completed frames.

Function
REQ-019 The FSM shall have states IDLE, ACTIVE, HBLANK and VBLANK; all outputs shall be registered.
REQ-020 From IDLE with enable=1, the block shall latch pattern and enter ACTIVE, presenting pixel (0,0) with pix_valid=1 on the next cycle.
REQ-021 In ACTIVE, pix_data, cnt_x, cnt_y, frame_start, line_end and roi shall hold stable while pix_valid && !ready, with no pixel dropped or duplicated.
REQ-022 On transfer of a pixel with x < H_ACT-1, the block shall present x+1 on the next cycle.
REQ-023 On transfer of a pixel with x = H_ACT-1, the block shall enter HBLANK with pix_valid=0 for exactly H_GAP cycles, regardless of ready.
REQ-024 At HBLANK end with y < V_ACT-1, the block shall return to ACTIVE with pixel (0, y+1).
REQ-025 At HBLANK end with y = V_ACT-1, the block shall increment frame_cnt (wrap 255->0) and enter VBLANK for V_GAP cycles.
REQ-026 At VBLANK end, the block shall re-sample enable and pattern: enable=1 starts a new frame at (0,0); enable=0 returns to IDLE.
REQ-027 Deasserting enable mid-frame shall have no effect until the frame completes; pattern changes mid-frame shall be ignored.
REQ-028 Pattern 0 shall output 8 vertical bars, each H_ACT/8 wide, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-029 Pattern 1 shall output a gray ramp with g = cnt_x[9:2] and pix_data = {g[7:3], g[7:2], g[7:3]}.
REQ-030 Pattern 2 shall output a 32x32 checkerboard: FFFF when cnt_x[5] ^ cnt_y[5], else 0000.
REQ-031 Pattern 3 shall output FFFF inside the ROI and 0000 outside it.
REQ-032 roi shall be 1 iff ROI_X0 <= cnt_x <= ROI_X1 and ROI_Y0 <= cnt_y <= ROI_Y1, in every pattern.
REQ-033 pix_data, frame_start, line_end and roi shall be meaningful only while pix_valid=1, and shall be driven 0 otherwise.

Reset
REQ-034 While rst=1 at a clock edge, the block shall enter IDLE and drive all outputs to 0, including cnt_x, cnt_y and frame_cnt.
REQ-035 Asserting rst mid-frame shall abort the frame without incrementing frame_cnt; after release with enable=1, streaming shall restart at (0,0) one cycle after the enable sample.

Verification
REQ-036 rst=1 then 0 with enable=0 -> all outputs stay 0 and the FSM stays in IDLE indefinitely.
REQ-037 enable=1, pattern=0, ready=1 -> pixel (0,0) has pix_data=FFFF and frame_start=1; x=100 gives FFE0; x=799 gives 0000 with line_end=1; then exactly 16 cycles with pix_valid=0.
REQ-038 ready toggled pseudo-randomly for one full frame -> exactly 480000 transfers with coordinates sequential and no gaps; frame_cnt goes 0->1 after the last line's HBLANK.
REQ-039 pattern=3 -> roi=1 and pix_data=FFFF at (150,50) and (450,350); roi=0 and pix_data=0000 at (149,50), (451,350) and (150,351).
REQ-040 pattern switched 0->2 and enable dropped mid-frame -> the frame finishes with pattern 0, then the FSM enters IDLE; re-enabling gives pattern 2 with (32,0)=FFFF and (32,32)=0000.
REQ-041 rst pulsed at (400,300) -> outputs 0 next cycle and frame_cnt unchanged at 0; a new frame then starts at (0,0).
